// File: rtl/pdu_pkg.sv
// Shared IO register map and view-select codes for the PDU breakpoint unit.
// Pure declarations: no latency, no flow control.
// Backpressure: none.
package pdu_pkg;

    localparam logic [7:0] IO_OUT0  = 8'h00;
    localparam logic [7:0] IO_READY = 8'h04;
    localparam logic [7:0] IO_OUT1  = 8'h08;
    localparam logic [7:0] IO_IN    = 8'h0C;
    localparam logic [7:0] IO_VALID = 8'h10;
    localparam logic [7:0] IO_STAT  = 8'h14;
    localparam logic [7:0] IO_BP    = 8'h18;
    localparam logic [7:0] IO_BPEN  = 8'h1C;
    localparam logic [7:0] IO_CYC   = 8'h20;

    localparam logic [31:0] OUT1_RST = 32'h1234_5678;

    typedef enum logic [1:0] {
        VIEW_OUT1 = 2'b00,
        VIEW_RF   = 2'b01,
        VIEW_MEM  = 2'b10,
        VIEW_PC   = 2'b11
    } view_t;

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser followed by a stability counter for one raw input bit.
// Latency: 2 sync cycles plus 2^DB_BITS cycles of stable input before dout moves.
// Backpressure: none; glitches shorter than the window are discarded.
module debounce #(
    parameter int DB_BITS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic               sync1;
    logic               sync2;
    logic [DB_BITS-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            // Count only while the synchronised level disagrees with the output.
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (&cnt) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pdu_bp.sv
// Debug unit: debounced panel inputs, run/step CPU clock, PC breakpoint, cycle counter, IO regs, 7-seg scan.
// Latency: IO reads combinational; writes, clk_cpu and halt take effect at the next clk edge.
// Backpressure: none; buttons are edge-detected after debounce, IO writes always accepted.
module pdu_bp
    import pdu_pkg::*;
#(
    parameter int IN_W      = 5,
    parameter int DIGITS    = 8,
    parameter int SCAN_BITS = 20,
    parameter int DB_BITS   = 16,
    localparam int DW       = $clog2(DIGITS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            step,
    input  logic            valid,
    input  logic [IN_W-1:0] in,
    output logic            clk_cpu,
    output logic [1:0]      check,
    output logic [IN_W-1:0] out0,
    output logic            ready,
    output logic            halted,
    output logic [DW-1:0]   an,
    output logic [3:0]      seg,
    input  logic [7:0]      io_addr,
    input  logic [31:0]     io_dout,
    input  logic            io_we,
    output logic [31:0]     io_din,
    output logic [7:0]      m_rf_addr,
    input  logic [31:0]     rf_data,
    input  logic [31:0]     m_data,
    input  logic [31:0]     pc
);

    logic            run_db, step_db, valid_db;
    logic [IN_W-1:0] in_db;
    logic            run_q, step_q, valid_q;
    logic            run_p, step_p, valid_pn;

    logic                 skip;
    logic                 bp_en;
    logic [31:0]          bp;
    logic [31:0]          cyc;
    logic [IN_W-1:0]      out0_r;
    logic [31:0]          out1_r;
    logic                 ready_r;
    logic [SCAN_BITS-1:0] scan;
    logic [31:0]          value;

    logic hit, clr_halt, cpu_nxt, cpu_rise;

    debounce #(.DB_BITS(DB_BITS)) u_db_run   (.clk(clk), .rst_n(rst_n), .din(run),   .dout(run_db));
    debounce #(.DB_BITS(DB_BITS)) u_db_step  (.clk(clk), .rst_n(rst_n), .din(step),  .dout(step_db));
    debounce #(.DB_BITS(DB_BITS)) u_db_valid (.clk(clk), .rst_n(rst_n), .din(valid), .dout(valid_db));

    for (genvar i = 0; i < IN_W; i++) begin : g_in
        debounce #(.DB_BITS(DB_BITS)) u_db_in (.clk(clk), .rst_n(rst_n), .din(in[i]), .dout(in_db[i]));
    end

    assign run_p    = run_db & ~run_q;
    assign step_p   = step_db & ~step_q;
    assign valid_pn = valid_db ^ valid_q;

    always_comb begin
        hit      = run_db & ~clk_cpu & ~halted & bp_en & (pc == bp) & ~skip;
        clr_halt = run_p | (io_we && io_addr == IO_BPEN);
        if (run_db && !halted) begin
            // A breakpoint hit parks the CPU clock low instead of raising it.
            cpu_nxt = hit ? 1'b0 : ~clk_cpu;
        end else begin
            cpu_nxt = step_p;
        end
        cpu_rise = cpu_nxt & ~clk_cpu;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            step_q  <= 1'b0;
            valid_q <= 1'b0;
            clk_cpu <= 1'b0;
            halted  <= 1'b0;
            skip    <= 1'b0;
            check   <= 2'b00;
            out0_r  <= '1;
            out1_r  <= OUT1_RST;
            ready_r <= 1'b1;
            bp      <= '0;
            bp_en   <= 1'b0;
            cyc     <= '0;
            scan    <= '0;
        end else begin
            run_q   <= run_db;
            step_q  <= step_db;
            valid_q <= valid_db;
            clk_cpu <= cpu_nxt;
            scan    <= scan + 1'b1;

            // Clearing a halt arms skip so the core can step off the breakpoint PC.
            if (clr_halt) begin
                halted <= 1'b0;
                skip   <= 1'b1;
            end else begin
                if (hit)      halted <= 1'b1;
                if (cpu_rise) skip   <= 1'b0;
            end

            if (io_we && io_addr == IO_CYC) begin
                cyc <= '0;
            end else if (cpu_rise) begin
                cyc <= cyc + 32'd1;
            end

            if (io_we) begin
                case (io_addr)
                    IO_OUT0:  out0_r  <= io_dout[IN_W-1:0];
                    IO_READY: ready_r <= io_dout[0];
                    IO_OUT1:  out1_r  <= io_dout;
                    IO_BP:    bp      <= io_dout;
                    IO_BPEN:  bp_en   <= io_dout[0];
                    default: ;
                endcase
            end

            if (run_db || step_p) begin
                check <= 2'b00;
            end else if (valid_pn) begin
                check <= check - 2'd1;
            end
        end
    end

    always_comb begin
        m_rf_addr             = '0;
        m_rf_addr[IN_W-1:0]   = in_db;
    end

    always_comb begin
        io_din = '0;
        case (io_addr)
            IO_IN:    io_din[IN_W-1:0] = in_db;
            IO_VALID: io_din[0]        = valid_db;
            IO_STAT:  io_din[1:0]      = {bp_en, halted};
            IO_BP:    io_din           = bp;
            IO_BPEN:  io_din[0]        = bp_en;
            IO_CYC:   io_din           = cyc;
            default: ;
        endcase
    end

    always_comb begin
        out0  = '0;
        value = '0;
        ready = 1'b0;
        case (check)
            VIEW_OUT1: begin
                out0  = out0_r;
                value = out1_r;
                ready = ready_r;
            end
            VIEW_RF: begin
                out0  = in_db;
                value = rf_data;
            end
            VIEW_MEM: begin
                out0  = in_db;
                value = m_data;
            end
            default: begin
                value = pc;
            end
        endcase
    end

    assign an  = scan[SCAN_BITS-1 -: DW];
    assign seg = 4'(value >> {an, 2'b00});

endmodule

// File: tb/tb_pdu_bp.sv
// Directed bench for pdu_bp: reset, display scan, breakpoint/step/resume, cycle clear, view select.
// A second small build (IN_W=8, DIGITS=4) checks the wide switch path.
module tb_pdu_bp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0, step = 1'b0, valid = 1'b0;
    logic [4:0]  in = '0;
    logic        clk_cpu, ready, halted;
    logic [1:0]  check;
    logic [4:0]  out0;
    logic [2:0]  an;
    logic [3:0]  seg;
    logic [7:0]  io_addr = '0;
    logic [31:0] io_dout = '0;
    logic        io_we = 1'b0;
    logic [31:0] io_din;
    logic [7:0]  m_rf_addr;
    logic [31:0] pc = '0;

    logic [7:0]  in_b = 8'hA5;
    logic [7:0]  io_addr_b = 8'h0C;
    logic        clk_cpu_b, ready_b, halted_b;
    logic [1:0]  check_b;
    logic [7:0]  out0_b;
    logic [1:0]  an_b;
    logic [3:0]  seg_b;
    logic [31:0] io_din_b;
    logic [7:0]  m_rf_addr_b;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Minimal core model: the PC advances by one word per CPU clock rising edge.
    always @(posedge clk_cpu) pc <= pc + 32'd4;

    pdu_bp #(.IN_W(5), .DIGITS(8), .SCAN_BITS(4), .DB_BITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .valid(valid), .in(in),
        .clk_cpu(clk_cpu), .check(check), .out0(out0), .ready(ready), .halted(halted),
        .an(an), .seg(seg), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
        .io_din(io_din), .m_rf_addr(m_rf_addr), .rf_data(32'hAAAA_0001),
        .m_data(32'hBBBB_0002), .pc(pc)
    );

    pdu_bp #(.IN_W(8), .DIGITS(4), .SCAN_BITS(4), .DB_BITS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .run(1'b0), .step(1'b0), .valid(1'b0), .in(in_b),
        .clk_cpu(clk_cpu_b), .check(check_b), .out0(out0_b), .ready(ready_b), .halted(halted_b),
        .an(an_b), .seg(seg_b), .io_addr(io_addr_b), .io_dout(32'h0), .io_we(1'b0),
        .io_din(io_din_b), .m_rf_addr(m_rf_addr_b), .rf_data(32'h0),
        .m_data(32'h0), .pc(32'h0)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic io_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        io_addr = a;
        io_dout = d;
        io_we   = 1'b1;
        @(negedge clk);
        io_we   = 1'b0;
    endtask

    task automatic io_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        @(negedge clk);
        io_addr = a;
        #1;
        chk(tag, io_din, exp);
    endtask

    task automatic wait_halt(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (halted) break;
        end
    endtask

    initial begin
        logic [31:0] pat;
        logic [31:0] bpv;
        int          hi;
        int          ea;

        pat = 32'h1234_5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        io_addr = 8'h14;
        #1;
        chk("rst_halted", halted, 0);
        chk("rst_clk_cpu", clk_cpu, 0);
        chk("rst_check", check, 0);
        chk("rst_out0", out0, 5'h1F);
        chk("rst_ready", ready, 1);
        chk("rst_stat", io_din, 0);

        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            ea = (i % 16) >> 1;
            chk("scan_an", an, ea);
            chk("scan_seg", seg, (pat >> (4 * ea)) & 32'hF);
        end

        io_chk("rst_bp", 8'h18, 0);
        io_chk("rst_cyc", 8'h20, 0);

        // Breakpoint at 0x10 while free-running.
        io_wr(8'h18, 32'h10);
        io_wr(8'h1C, 32'h1);
        run = 1'b1;
        wait_halt(200);
        chk("bp_halted", halted, 1);
        chk("bp_pc", pc, 32'h10);
        chk("bp_clk_low", clk_cpu, 0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (clk_cpu) hi++;
        end
        chk("bp_clk_stays_low", hi, 0);
        io_chk("bp_stat", 8'h14, 3);
        io_chk("bp_cyc", 8'h20, 4);

        // Single step while halted.
        step = 1'b1;
        hi = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (i == 25) step = 1'b0;
            if (clk_cpu) hi++;
        end
        chk("step_pulses", hi, 1);
        chk("step_halted", halted, 1);
        chk("step_pc", pc, 32'h14);
        io_chk("step_cyc", 8'h20, 5);

        // Resume via a fresh run edge.
        run = 1'b0;
        cycles(20);
        run = 1'b1;
        cycles(30);
        chk("resume_halted", halted, 0);
        chk("resume_pc_past", pc > 32'h14, 1);

        // Clearing the halt by writing bp_en must step off the breakpoint PC.
        @(negedge clk);
        bpv = pc + 32'd16;
        io_wr(8'h18, bpv);
        wait_halt(100);
        chk("bp2_halted", halted, 1);
        chk("bp2_pc", pc, bpv);
        io_wr(8'h1C, 32'h1);
        cycles(8);
        chk("skip_halted", halted, 0);
        chk("skip_pc_past", pc > bpv, 1);

        // Cycle-counter clear coinciding with a CPU clock rising edge.
        @(negedge clk);
        if (clk_cpu) @(negedge clk);
        io_addr = 8'h20;
        io_dout = 32'h0;
        io_we   = 1'b1;
        @(negedge clk);
        io_we   = 1'b0;
        #1;
        chk("cyc_clr_rise_seen", clk_cpu, 1);
        chk("cyc_clr_wins", io_din, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("cyc_after_clr", io_din, 1);

        // View select driven by valid edges.
        run = 1'b0;
        in  = 5'h15;
        cycles(20);
        chk("view_initial", check, 0);
        valid = 1'b1;
        cycles(3);
        valid = 1'b0;
        cycles(20);
        chk("glitch_check", check, 0);
        valid = 1'b1;
        cycles(20);
        chk("valid_rise_check", check, 3);
        chk("view3_out0", out0, 0);
        chk("view3_ready", ready, 0);
        io_chk("rd_valid", 8'h10, 1);
        valid = 1'b0;
        cycles(20);
        chk("valid_fall_check", check, 2);
        chk("view2_out0", out0, 5'h15);
        chk("view2_ready", ready, 0);
        chk("m_rf_addr", m_rf_addr, 8'h15);
        io_chk("rd_in", 8'h0C, 32'h15);

        step = 1'b1;
        cycles(20);
        step = 1'b0;
        cycles(20);
        chk("step_view_reset", check, 0);
        chk("view0_ready", ready, 1);
        io_wr(8'h00, 32'h0A);
        io_wr(8'h04, 32'h0);
        #1;
        chk("wr_out0", out0, 5'h0A);
        chk("wr_ready", ready, 0);
        io_chk("rd_stat_end", 8'h14, 2);
        io_chk("rd_unmapped", 8'h24, 0);

        // Wide-switch build.
        #1;
        chk("b_rd_in", io_din_b, 32'h0000_00A5);
        chk("b_m_rf_addr", m_rf_addr_b, 8'hA5);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, tests run %0d", n_run);
        $fatal(1);
    end

endmodule

// File: doc/pdu_bp.md
PDU_BP -- requirements
Module: pdu_bp

Interface
REQ-001 SHALL have parameter IN_W, default 5, switch input and register-address width (1..8).
REQ-002 SHALL have parameter DIGITS, default 8, seven-segment digit count (power of 2, 2..8); DW = log2(DIGITS).
REQ-003 SHALL have parameter SCAN_BITS, default 20, scan counter width; digit select = top DW bits.
REQ-004 SHALL have parameter DB_BITS, default 16, debounce counter width.
REQ-005 SHALL have ports: clk in 1 system clock; rst_n in 1 reset. The reset is synchronous and active-low.
REQ-006 SHALL have ports: run, step, valid in 1 raw buttons/switches; in in IN_W raw switches.
REQ-007 SHALL have ports: clk_cpu out 1; check out 2; out0 out IN_W; ready out 1; halted out 1; an out DW; seg out 4.
REQ-008 SHALL have ports: io_addr in 8; io_dout in 32; io_we in 1; io_din out 32.
REQ-009 SHALL have ports: m_rf_addr out 8 = zero-extended debounced in; rf_data, m_data, pc in 32.

Function
REQ-010 SHALL pass run, step, valid and in through a 2-flop synchroniser, then debounce each; a debounced value updates only after the synchronised value is stable for 2^DB_BITS clk cycles.
REQ-011 SHALL define step_p as a debounced step rising edge, run_p as a debounced run rising edge, and valid_pn as any debounced valid edge; each is exactly 1 clk wide.
REQ-012 SHALL, while run is 1 and halted is 0, toggle clk_cpu every clk; otherwise it SHALL drive clk_cpu = step_p (one-clk pulse).
REQ-013 SHALL hold breakpoint register bp (32b) and bp_en (1b); on a clk where run is 1, clk_cpu is 0, halted is 0, bp_en is 1, pc == bp and skip is 0, it SHALL set halted and leave clk_cpu at 0.
REQ-014 SHALL clear halted on run_p, and also on any write to 0x1C; a clear SHALL set skip, which suppresses matching until the next clk_cpu rising edge, so the core can leave the breakpoint PC.
REQ-015 SHALL count clk_cpu rising edges in cyc (32b, wraps 0xFFFFFFFF->0); an IO write to 0x20 SHALL clear it, and the write wins over a simultaneous increment.
REQ-016 SHALL implement IO reads (combinational) as:
- 0x0C = in;
- 0x10 = valid;
- 0x14 = {30'b0, bp_en, halted};
- 0x18 = bp;
- 0x1C = bp_en;
- 0x20 = cyc;
- all other addresses = 0.
REQ-017 SHALL implement IO writes (when io_we is 1, registered) as:
- 0x00 out0_r = io_dout[IN_W-1:0];
- 0x04 ready_r = io_dout[0];
- 0x08 out1_r = io_dout;
- 0x18 bp = io_dout;
- 0x1C bp_en = io_dout[0];
- 0x20 cyc cleared;
- all other addresses ignored.
REQ-018 SHALL implement view register check (2b): forced to 00 when run is 1 or on step_p; otherwise decremented mod 4 on valid_pn (00->11 wraps). If step_p and valid_pn occur together, step_p wins.
REQ-019 SHALL select view outputs as:
- 00: out0 = out0_r, value = out1_r, ready = ready_r;
- 01: out0 = in, value = rf_data;
- 10: out0 = in, value = m_data;
- 11: out0 = 0, value = pc.
ready SHALL be 0 in views other than 00.
REQ-020 SHALL drive seg = value nibble an; the upper nibbles are not shown when DIGITS < 8.
REQ-021 SHALL increment the scan counter every clk and let it wrap freely.

Reset
REQ-022 SHALL, on rst_n = 0 at a clk edge, reset:
- clk_cpu = 0, halted = 0, skip = 0;
- check = 00;
- out0_r = all ones, out1_r = 0x12345678, ready_r = 1;
- bp = 0, bp_en = 0, cyc = 0;
- scan, debounce and synchroniser state = 0.
REQ-023 SHALL, on reset while halted or mid-debounce, abandon all state; no clk_cpu pulse is emitted in the reset cycle.

Structure
REQ-024 SHALL define IO address constants and view codes in shared package pdu_pkg.
REQ-025 SHALL instantiate one sub-module per input bit, debounce (parameter DB_BITS, sync plus stable counter).

Verification
REQ-026 SHALL cover: reset, then read 0x14 -> 0; out1 view shows 12345678 and an sweeps 0..DIGITS-1.
REQ-027 SHALL cover: run = 1 with bp = 0x10, bp_en = 1 and pc stepping by 4 -> halted rises when pc = 0x10, and clk_cpu stays 0.
REQ-028 SHALL cover: while halted, pulse step -> exactly one clk_cpu pulse and cyc +1; then run_p -> run resumes past 0x10 with no re-halt.
REQ-029 SHALL cover: a 3-cycle glitch on valid -> check unchanged; a stable valid toggle -> check 00->11->10.
REQ-030 SHALL cover: io_we write 0x20 in the same clk as a clk_cpu rising edge -> cyc reads 0.
REQ-031 SHALL cover: IN_W = 8, DIGITS = 4 build; in = 0xA5 -> read 0x0C returns 0x000000A5 and m_rf_addr = 0xA5.
